time_setter: RTL and testbench

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter.sv | 142 ++++++++++++++
 tb/tb_time_setter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_setter.sv
// Time-setting front end: captures the running time, lets the user step hour/min/sec,
// then strobes the edited value into the clock core for one cycle.
module time_setter #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  input  logic [16:0] time_cur,
  output logic [16:0] time_set,
  output logic        time_ow,
  output logic        editing,
  output logic [1:0]  edit_field
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StEditHour,
    StEditMin,
    StEditSec,
    StCommit
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mode_q, inc_q, dec_q, cancel_q;
  logic            mode_e, inc_e, dec_e, cancel_e, any_edge, timeout;
  logic [1:0]      field_d;

  // Wrap-around step; inc and dec together leave the value alone.
  function automatic logic [5:0] step(input logic [5:0] val, input logic [5:0] max,
                                      input logic inc, input logic dec);
    if (inc && !dec) begin
      return (val >= max) ? 6'd0 : val + 6'd1;
    end else if (dec && !inc) begin
      return (val == 6'd0 || val > max) ? max : val - 6'd1;
    end
    return val;
  endfunction

  assign mode_e   = btn_mode & ~mode_q;
  assign inc_e    = btn_inc & ~inc_q;
  assign dec_e    = btn_dec & ~dec_q;
  assign cancel_e = btn_cancel & ~cancel_q;
  assign any_edge = mode_e | inc_e | dec_e | cancel_e;
  assign timeout  = (TIMEOUT_CYC != 0) && !any_edge && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mode_e) begin
          state_d                = StEditHour;
          {hour_d, min_d, sec_d} = time_cur;
          cnt_d                  = '0;
        end
      end
      StEditHour, StEditMin, StEditSec: begin
        cnt_d = any_edge ? '0 : cnt_q + CntW'(1);
        if (cancel_e || timeout) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (mode_e) begin
          if (state_q == StEditHour)     state_d = StEditMin;
          else if (state_q == StEditMin) state_d = StEditSec;
          else                           state_d = StCommit;
        end else if (state_q == StEditHour) begin
          hour_d = 5'(step({1'b0, hour_q}, 6'd23, inc_e, dec_e));
        end else if (state_q == StEditMin) begin
          min_d = step(min_q, 6'd59, inc_e, dec_e);
        end else begin
          sec_d = step(sec_q, 6'd59, inc_e, dec_e);
        end
      end
      StCommit: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    field_d = 2'b00;
    unique case (state_d)
      StEditHour: field_d = 2'b01;
      StEditMin:  field_d = 2'b10;
      StEditSec:  field_d = 2'b11;
      default:    field_d = 2'b00;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b1;
      inc_q      <= 1'b1;
      dec_q      <= 1'b1;
      cancel_q   <= 1'b1;
      time_ow    <= 1'b0;
      editing    <= 1'b0;
      edit_field <= 2'b00;
    end else begin
      state_q    <= state_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      cnt_q      <= cnt_d;
      mode_q     <= btn_mode;
      inc_q      <= btn_inc;
      dec_q      <= btn_dec;
      cancel_q   <= btn_cancel;
      time_ow    <= (state_d == StCommit);
      editing    <= (field_d != 2'b00);
      edit_field <= field_d;
    end
  end

  assign time_set = {hour_q, min_q, sec_q};

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: entry/commit, wrap, out-of-range capture, cancel,
// timeout and reset behaviour, with hand-computed expectations.
module tb_time_setter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
  logic [16:0] time_cur = '0;
  logic [16:0] time_set;
  logic        time_ow, editing;
  logic [1:0]  edit_field;

  int tests = 0;
  int fails = 0;
  int ow_count = 0;

  time_setter #(.TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_cancel (btn_cancel),
    .time_cur   (time_cur),
    .time_set   (time_set),
    .time_ow    (time_ow),
    .editing    (editing),
    .edit_field (edit_field)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (time_ow === 1'b1) ow_count++;

  function automatic logic [16:0] tm(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, then buttons high for exactly one sampled edge; returns just after it.
  task automatic press(input logic c, input logic m, input logic i, input logic d);
    tick();
    {btn_cancel, btn_mode, btn_inc, btn_dec} = {c, m, i, d};
    tick();
    {btn_cancel, btn_mode, btn_inc, btn_dec} = 4'b0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++; if (time_set !== 17'd0) begin fails++;
      $display("FAIL reset_time_set: got %h want 0", time_set); end
    tests++; if (time_ow !== 1'b0) begin fails++;
      $display("FAIL reset_time_ow: got %b want 0", time_ow); end
    tests++; if (editing !== 1'b0) begin fails++;
      $display("FAIL reset_editing: got %b want 0", editing); end
    tests++; if (edit_field !== 2'b00) begin fails++;
      $display("FAIL reset_edit_field: got %b want 00", edit_field); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int snap;
    time_cur = tm(12, 34, 56);
    press(0, 1, 0, 0);
    tests++; if ({editing, edit_field} !== 3'b101) begin fails++;
      $display("FAIL basic_enter: got %b%b want 1 01", editing, edit_field); end
    tests++; if (time_set !== tm(12, 34, 56)) begin fails++;
      $display("FAIL basic_capture: got %h want %h", time_set, tm(12, 34, 56)); end
    time_cur = tm(1, 2, 3);
    press(0, 1, 0, 0);
    tests++; if (edit_field !== 2'b10) begin fails++;
      $display("FAIL basic_min: got %b want 10", edit_field); end
    press(0, 1, 0, 0);
    tests++; if (edit_field !== 2'b11) begin fails++;
      $display("FAIL basic_sec: got %b want 11", edit_field); end
    snap = ow_count;
    press(0, 1, 0, 0);
    tests++; if ({time_ow, editing, edit_field} !== 4'b1000) begin fails++;
      $display("FAIL basic_commit: got ow=%b ed=%b f=%b want 1 0 00",
               time_ow, editing, edit_field); end
    tests++; if (time_set !== tm(12, 34, 56)) begin fails++;
      $display("FAIL basic_commit_value: got %h want %h", time_set, tm(12, 34, 56)); end
    tick();
    tests++; if (time_ow !== 1'b0 || ow_count != snap + 1) begin fails++;
      $display("FAIL basic_one_pulse: got ow=%b pulses=%0d want 0 1", time_ow,
               ow_count - snap); end
  endtask

  task automatic test_wrap();
    time_cur = tm(23, 0, 7);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    tests++; if (time_set !== tm(0, 0, 7)) begin fails++;
      $display("FAIL wrap_hour_inc: got %h want %h", time_set, tm(0, 0, 7)); end
    press(0, 0, 0, 1);
    tests++; if (time_set !== tm(23, 0, 7)) begin fails++;
      $display("FAIL wrap_hour_dec: got %h want %h", time_set, tm(23, 0, 7)); end
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    tests++; if (time_set !== tm(23, 59, 7)) begin fails++;
      $display("FAIL wrap_min_dec: got %h want %h", time_set, tm(23, 59, 7)); end
    press(0, 0, 1, 0);
    tests++; if (time_set !== tm(23, 0, 7)) begin fails++;
      $display("FAIL wrap_min_inc: got %h want %h", time_set, tm(23, 0, 7)); end
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    tests++; if (time_set !== tm(23, 0, 8)) begin fails++;
      $display("FAIL sec_inc: got %h want %h", time_set, tm(23, 0, 8)); end
    press(0, 0, 1, 1);
    tests++; if (time_set !== tm(23, 0, 8)) begin fails++;
      $display("FAIL inc_dec_together: got %h want %h", time_set, tm(23, 0, 8)); end
    press(1, 0, 0, 0);
    tests++; if ({editing, time_ow} !== 2'b00) begin fails++;
      $display("FAIL wrap_cancel: got ed=%b ow=%b want 0 0", editing, time_ow); end
  endtask

  task automatic test_out_of_range();
    time_cur = tm(30, 61, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    tests++; if (time_set !== tm(0, 61, 0)) begin fails++;
      $display("FAIL oor_hour_inc: got %h want %h", time_set, tm(0, 61, 0)); end
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    tests++; if (time_set !== tm(0, 0, 0)) begin fails++;
      $display("FAIL oor_min_inc: got %h want %h", time_set, tm(0, 0, 0)); end
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    tests++; if (time_set !== tm(23, 61, 0)) begin fails++;
      $display("FAIL oor_hour_dec: got %h want %h", time_set, tm(23, 61, 0)); end
    press(1, 0, 0, 0);
  endtask

  task automatic test_cancel();
    int snap;
    time_cur = tm(12, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    tests++; if (time_set !== tm(13, 0, 0)) begin fails++;
      $display("FAIL cancel_inc: got %h want %h", time_set, tm(13, 0, 0)); end
    snap = ow_count;
    press(1, 0, 0, 0);
    tests++; if ({editing, edit_field} !== 3'b000) begin fails++;
      $display("FAIL cancel_idle: got %b%b want 0 00", editing, edit_field); end
    repeat (100) tick();
    tests++; if (ow_count != snap) begin fails++;
      $display("FAIL cancel_no_ow: got %0d pulses want 0", ow_count - snap); end
    press(0, 0, 1, 0);
    tests++; if ({editing, time_set} !== {1'b0, tm(13, 0, 0)}) begin fails++;
      $display("FAIL idle_inc_ignored: got ed=%b t=%h want 0 %h", editing, time_set,
               tm(13, 0, 0)); end
    press(0, 1, 0, 0);
    press(1, 1, 0, 0);
    tests++; if ({editing, edit_field} !== 3'b000) begin fails++;
      $display("FAIL cancel_beats_mode: got %b%b want 0 00", editing, edit_field); end
  endtask

  task automatic test_timeout();
    int n;
    int snap;
    snap = ow_count;
    time_cur = tm(5, 6, 7);
    press(0, 1, 0, 0);
    n = 0;
    while (editing === 1'b1 && n < 100) begin tick(); n++; end
    tests++; if (n != 16) begin fails++;
      $display("FAIL timeout_len: got %0d cycles want 16", n); end
    press(0, 1, 0, 0);
    repeat (9) tick();
    press(0, 0, 1, 0);
    tests++; if ({editing, time_set} !== {1'b1, tm(6, 6, 7)}) begin fails++;
      $display("FAIL timeout_inc: got ed=%b t=%h want 1 %h", editing, time_set,
               tm(6, 6, 7)); end
    n = 0;
    while (editing === 1'b1 && n < 100) begin tick(); n++; end
    tests++; if (n != 16) begin fails++;
      $display("FAIL timeout_restart: got %0d cycles want 16", n); end
    tests++; if (ow_count != snap) begin fails++;
      $display("FAIL timeout_no_ow: got %0d pulses want 0", ow_count - snap); end
  endtask

  task automatic test_reset_abort();
    int snap;
    rst_n = 1'b0;
    btn_mode = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    tests++; if (editing !== 1'b0) begin fails++;
      $display("FAIL held_mode_no_entry: got %b want 0", editing); end
    btn_mode = 1'b0;
    time_cur = tm(9, 8, 7);
    snap = ow_count;
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({editing, edit_field, time_ow, time_set} !== 21'd0) begin fails++;
      $display("FAIL reset_mid_edit: got ed=%b f=%b ow=%b t=%h want all 0",
               editing, edit_field, time_ow, time_set); end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    tests++; if (ow_count != snap || editing !== 1'b0) begin fails++;
      $display("FAIL reset_edit_after: got pulses=%0d ed=%b want 0 0", ow_count - snap,
               editing); end
    repeat (4) press(0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    tests++; if (time_ow !== 1'b0) begin fails++;
      $display("FAIL reset_in_commit: got %b want 0", time_ow); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    tests++; if (ow_count != snap) begin fails++;
      $display("FAIL reset_commit_no_ow: got %0d pulses want 0", ow_count - snap); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_out_of_range();
    test_cancel();
    test_timeout();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
